wb_dcache: RTL and testbench
============================

WB_DCACHE -- requirements
Module: wb_dcache

Interface
REQ-001 Parameters, one per line:
- LINES, default 8, number of direct-mapped 128-bit lines (power of 2, 2..64).
- IDX_W, default $clog2(LINES), index width taken from the low bits of the 12-bit line address.

REQ-002 One clock; reset is synchronous and active-high.

REQ-003 Ports, one per line:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_ADR  in  12  line address (byte addr [15:4])
- cpu_CYC  in  1  bus cycle active
- cpu_STB  in  1  request strobe
- cpu_WE  in  1  1=write, 0=read
- cpu_SEL  in  16  byte enables within line
- cpu_DAT_M  in  128  write data, byte-lane aligned
- cpu_DAT_S  out  128  read data (full line)
- cpu_ACK  out  1  request complete
- cpu_RTY  out  1  miss service in progress
- mem_ADR  out  12  backing-memory line address
- mem_CYC  out  1  memory cycle active
- mem_STB  out  1  memory strobe
- mem_WE  out  1  memory write
- mem_SEL  out  16  memory byte enables
- mem_DAT_M  out  128  writeback data
- mem_DAT_S  in  128  fill data
- mem_ACK  in  1  memory transfer complete
- mem_RTY  in  1  memory busy, treated as not-ACK

REQ-004 The cpu_* and mem_* groups are the wishbone slave and master modports of the existing wishbone interface.

Function
REQ-005 Storage per line: valid, dirty, tag = cpu_ADR[11:IDX_W], 128-bit data; index = cpu_ADR[IDX_W-1:0].

REQ-006 States: IDLE, RESPOND, WRITEBACK, FILL.

REQ-007 Request = cpu_CYC & cpu_STB, sampled only in IDLE.

REQ-008 Hit = valid & tag match.

REQ-009 IDLE, request, read hit -> RESPOND:
- cpu_DAT_S registered with line data.
- cpu_ACK=1 for exactly the following cycle.

REQ-010 IDLE, request, write hit -> RESPOND:
- Each byte b with cpu_SEL[b]=1 is replaced by cpu_DAT_M[8b+:8].
- dirty=1.
- cpu_DAT_S = merged line.
- cpu_ACK=1 next cycle.

REQ-011 RESPOND always returns to IDLE; cpu_ACK is a 1-cycle pulse. Requests are not sampled in the ACK cycle, so maximum throughput is one hit per 2 cycles.

REQ-012 IDLE, request, miss: dirty victim -> WRITEBACK; else -> FILL.

REQ-013 WRITEBACK drives:
- mem_CYC=mem_STB=mem_WE=1, mem_SEL=16'hFFFF.
- mem_ADR = {victim tag, index}, mem_DAT_M = victim line.
- Holds until mem_ACK; then dirty=0 and -> FILL.

REQ-014 FILL drives:
- mem_CYC=mem_STB=1, mem_WE=0, mem_SEL=16'hFFFF, mem_ADR=cpu_ADR.
- On mem_ACK: line = mem_DAT_S, valid=1, dirty=0, tag written; -> IDLE.
- The request then hits on re-evaluation.

REQ-015 mem_ACK is sampled only in WRITEBACK/FILL. mem_RTY with or without mem_ACK=0 means wait, outputs unchanged. mem_ACK&mem_RTY counts as ACK.

REQ-016 mem_CYC/STB/WE are 0 in IDLE and RESPOND.

REQ-017 cpu_RTY=1 exactly in WRITEBACK/FILL.

REQ-018 cpu_ACK is never 1 outside RESPOND.

REQ-019 cpu_CYC/STB dropped mid-miss: the miss completes (line filled), no ACK issued, returns to IDLE.

REQ-020 cpu_ADR/WE/SEL/DAT_M are held stable by the master while a request is pending; behaviour is undefined otherwise.

REQ-021 cpu_DAT_S changes only on entry to RESPOND; otherwise it holds its value.

Reset
REQ-022 rst=1 at a clock edge (any state, including mid-miss):
- state=IDLE.
- All valid and dirty bits=0.
- cpu_ACK=0, cpu_RTY=0, cpu_DAT_S=0.
- mem_CYC/STB/WE=0, mem_ADR=0, mem_SEL=0, mem_DAT_M=0.

REQ-023 Line data and tags are not reset.

Verification
REQ-024 Cold read of cpu_ADR=12'h010, mem_ACK 3 cycles after mem_STB with mem_DAT_S=X:
- FILL is 3 cycles, then IDLE.
- cpu_ACK on the 2nd cycle after FILL ends, with cpu_DAT_S=X.
- cpu_RTY=1 throughout FILL.

REQ-025 Write hit to 12'h010, SEL=16'h0003, DAT_M[15:0]=16'hBEEF:
- ACK the next cycle.
- A re-read returns X with bytes 1:0 = BEEF.
- No mem_STB.

REQ-026 Read of conflicting 12'h018 (same index 0, LINES=8) after REQ-025:
- WRITEBACK with mem_ADR=12'h010, mem_WE=1, mem_DAT_M = merged line.
- Then FILL with mem_ADR=12'h018.
- Then ACK.

REQ-027 mem_RTY=1 for 4 cycles before mem_ACK during FILL:
- mem_STB held.
- No cpu_ACK until the fill completes.

REQ-028 rst asserted in the 2nd FILL cycle:
- The next cycle has mem_STB=0 and cpu_RTY=0.
- A re-read of 12'h010 misses (valid cleared).

REQ-029 Back-to-back read hits with STB held:
- ACKs occur on alternating cycles.
- Never two consecutive ACK cycles.

Source files
------------

// File: rtl/wb_dcache_if.sv
// Wishbone line bus (12-bit line address, 128-bit data, 16 byte lanes).
// Master drives the request side and slave drives the response side.
interface wb_dcache_if;
    logic [11:0]  ADR;
    logic         CYC;
    logic         STB;
    logic         WE;
    logic [15:0]  SEL;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S;
    logic         ACK;
    logic         RTY;

    modport master (output ADR, CYC, STB, WE, SEL, DAT_M, input DAT_S, ACK, RTY);
    modport slave  (input ADR, CYC, STB, WE, SEL, DAT_M, output DAT_S, ACK, RTY);
endinterface

// File: rtl/wb_dcache.sv
// Direct-mapped write-back data cache with 128-bit lines between a wishbone
// CPU slave port and a wishbone backing-memory master port.
module wb_dcache #(
    parameter int unsigned LINES = 8,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst,
    wb_dcache_if.slave  cpu,
    wb_dcache_if.master mem
);
    localparam int unsigned TAG_W = 12 - IDX_W;

    typedef enum logic [1:0] {IDLE, RESPOND, WRITEBACK, FILL} state_t;

    state_t state, state_nxt;

    logic [127:0]     data_mem [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [127:0]     dat_s_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] victim_tag;
    logic [127:0]     line;
    logic [127:0]     merged;
    logic             req;
    logic             hit;
    logic             hit_go;
    logic             wb_done;
    logic             fill_done;

    assign idx        = cpu.ADR[IDX_W-1:0];
    assign tag        = cpu.ADR[11:IDX_W];
    assign line       = data_mem[idx];
    assign victim_tag = tag_mem[idx];
    assign req        = cpu.CYC & cpu.STB;
    assign hit        = valid_q[idx] & (victim_tag == tag);
    assign hit_go     = (state == IDLE) & req & hit;
    // mem.RTY alone is simply "no ACK yet"; ACK wins when both are high.
    assign wb_done    = (state == WRITEBACK) & mem.ACK;
    assign fill_done  = (state == FILL) & mem.ACK;
    assign cpu.DAT_S  = dat_s_q;

    always_comb begin
        merged = line;
        for (int unsigned b = 0; b < 16; b++) begin
            if (cpu.SEL[b[3:0]]) merged[8*b +: 8] = cpu.DAT_M[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cpu.ACK       = 1'b0;
        cpu.RTY       = 1'b0;
        mem.CYC       = 1'b0;
        mem.STB       = 1'b0;
        mem.WE        = 1'b0;
        mem.SEL       = '0;
        mem.ADR       = '0;
        mem.DAT_M     = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit)               state_nxt = RESPOND;
                    else if (dirty_q[idx]) state_nxt = WRITEBACK;
                    else                   state_nxt = FILL;
                end
            end
            RESPOND: begin
                cpu.ACK   = 1'b1;
                state_nxt = IDLE;
            end
            WRITEBACK: begin
                cpu.RTY   = 1'b1;
                mem.CYC   = 1'b1;
                mem.STB   = 1'b1;
                mem.WE    = 1'b1;
                mem.SEL   = '1;
                mem.ADR   = {victim_tag, idx};
                mem.DAT_M = line;
                if (mem.ACK) state_nxt = FILL;
            end
            FILL: begin
                cpu.RTY = 1'b1;
                mem.CYC = 1'b1;
                mem.STB = 1'b1;
                mem.SEL = '1;
                mem.ADR = cpu.ADR;
                if (mem.ACK) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            dat_s_q <= '0;
        end else begin
            if (hit_go) begin
                dat_s_q <= cpu.WE ? merged : line;
                if (cpu.WE) dirty_q[idx] <= 1'b1;
            end
            if (wb_done) dirty_q[idx] <= 1'b0;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Line data and tags carry no reset; valid_q alone decides whether they count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit_go && cpu.WE) data_mem[idx] <= merged;
            if (fill_done) begin
                data_mem[idx] <= mem.DAT_S;
                tag_mem[idx]  <= tag;
            end
        end
    end
endmodule

// File: tb/tb_wb_dcache.sv
// Directed bench for wb_dcache: CPU responses and memory transfers are
// scoreboarded against hand-computed expectations queued by the stimulus.
module tb_wb_dcache;
    localparam logic [127:0] X   = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] MRG = 128'h00112233445566778899AABBCCDDBEEF;
    localparam logic [127:0] Y   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] Z   = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

    typedef struct {
        logic         we;
        logic [11:0]  adr;
        logic [127:0] dat;
    } mexp_t;

    logic clk;
    logic rst;

    wb_dcache_if cpu ();
    wb_dcache_if mem ();

    wb_dcache #(.LINES(8)) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu),
        .mem (mem)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q [$];
    mexp_t        mem_q [$];
    logic [127:0] bmem  [logic [11:0]];

    int unsigned lat   = 3;
    int unsigned rty_n = 0;
    int unsigned mcnt  = 0;
    logic        prev_ack = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Backing memory: ACK arrives on the lat-th strobe cycle, RTY on the first rty_n.
    always @(negedge clk) begin
        mexp_t e;
        if (rst || !mem.STB) begin
            mcnt    = 0;
            mem.ACK = 1'b0;
            mem.RTY = 1'b0;
        end else begin
            if (mem.ACK) mcnt = 0;
            mcnt++;
            mem.RTY = (mcnt <= rty_n);
            mem.ACK = (mcnt == lat);
            if (mem.ACK) begin
                if (mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got transfer adr %h we %b expected none", mem.ADR, mem.WE);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_we", mem.WE, e.we);
                    chk("mem_adr", mem.ADR, e.adr);
                    chk("mem_sel", mem.SEL, 16'hFFFF);
                    if (e.we) begin
                        chk("mem_dat_m", mem.DAT_M, e.dat);
                        bmem[mem.ADR] = mem.DAT_M;
                    end else begin
                        mem.DAT_S = bmem.exists(mem.ADR) ? bmem[mem.ADR] : '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cpu.ACK) begin
            chk("ack_spacing", prev_ack, 1'b0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cpu_unexpected_ack: got ACK with dat %h expected none", cpu.DAT_S);
            end else begin
                chk("cpu_dat_s", cpu.DAT_S, exp_q.pop_front());
            end
        end
        prev_ack = cpu.ACK;
    end

    task automatic cpu_req(input logic [11:0] a, input logic we, input logic [15:0] sel,
                           input logic [127:0] d, output int rty_cnt, output int stb_cnt,
                           output int ack_i);
        @(posedge clk); #1;
        cpu.ADR   = a;
        cpu.WE    = we;
        cpu.SEL   = sel;
        cpu.DAT_M = d;
        cpu.CYC   = 1'b1;
        cpu.STB   = 1'b1;
        rty_cnt = 0;
        stb_cnt = 0;
        ack_i   = -1;
        for (int i = 0; i < 40 && ack_i < 0; i++) begin
            @(negedge clk);
            if (cpu.RTY) rty_cnt++;
            if (mem.STB) stb_cnt++;
            if (cpu.ACK) ack_i = i;
        end
        if (ack_i < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got no ACK for adr %h expected ACK within 40 cycles", a);
        end
        @(posedge clk); #1;
        cpu.CYC = 1'b0;
        cpu.STB = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1);
    end

    initial begin
        int rc, sc, ai, acks;
        rst       = 1'b1;
        cpu.ADR   = '0;
        cpu.CYC   = 1'b0;
        cpu.STB   = 1'b0;
        cpu.WE    = 1'b0;
        cpu.SEL   = '0;
        cpu.DAT_M = '0;
        bmem[12'h010] = X;
        bmem[12'h018] = Y;
        bmem[12'h028] = Z;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_cpu_ack", cpu.ACK, 1'b0);
        chk("rst_cpu_rty", cpu.RTY, 1'b0);
        chk("rst_cpu_dat_s", cpu.DAT_S, '0);
        chk("rst_mem_cyc", mem.CYC, 1'b0);
        chk("rst_mem_stb", mem.STB, 1'b0);
        chk("rst_mem_we", mem.WE, 1'b0);
        chk("rst_mem_adr", mem.ADR, '0);
        chk("rst_mem_sel", mem.SEL, '0);
        chk("rst_mem_dat_m", mem.DAT_M, '0);

        mem_q.push_back('{1'b0, 12'h010, '0});
        exp_q.push_back(X);
        cpu_req(12'h010, 1'b0, '0, '0, rc, sc, ai);
        chk("cold_rty_cycles", rc, 3);
        chk("cold_stb_cycles", sc, 3);
        chk("cold_ack_cycle", ai, 5);

        exp_q.push_back(MRG);
        cpu_req(12'h010, 1'b1, 16'h0003, {112'h0, 16'hBEEF}, rc, sc, ai);
        chk("wrhit_rty_cycles", rc, 0);
        chk("wrhit_stb_cycles", sc, 0);
        chk("wrhit_ack_cycle", ai, 1);

        exp_q.push_back(MRG);
        cpu_req(12'h010, 1'b0, '0, '0, rc, sc, ai);
        chk("reread_stb_cycles", sc, 0);
        chk("reread_ack_cycle", ai, 1);

        mem_q.push_back('{1'b1, 12'h010, MRG});
        mem_q.push_back('{1'b0, 12'h018, '0});
        exp_q.push_back(Y);
        cpu_req(12'h018, 1'b0, '0, '0, rc, sc, ai);
        chk("conflict_rty_cycles", rc, 6);
        chk("conflict_stb_cycles", sc, 6);
        chk("conflict_ack_cycle", ai, 8);

        lat   = 5;
        rty_n = 4;
        mem_q.push_back('{1'b0, 12'h010, '0});
        exp_q.push_back(MRG);
        cpu_req(12'h010, 1'b0, '0, '0, rc, sc, ai);
        chk("memrty_rty_cycles", rc, 5);
        chk("memrty_stb_cycles", sc, 5);
        chk("memrty_ack_cycle", ai, 7);
        lat   = 3;
        rty_n = 0;

        repeat (3) exp_q.push_back(MRG);
        @(posedge clk); #1;
        cpu.ADR = 12'h010;
        cpu.WE  = 1'b0;
        cpu.CYC = 1'b1;
        cpu.STB = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu.ACK) acks++;
        end
        @(posedge clk); #1;
        cpu.CYC = 1'b0;
        cpu.STB = 1'b0;
        chk("b2b_ack_count", acks, 3);

        @(posedge clk); #1;
        cpu.ADR = 12'h020;
        cpu.CYC = 1'b1;
        cpu.STB = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstfill_started", mem.STB, 1'b1);
        @(posedge clk); #1;
        rst     = 1'b1;
        cpu.CYC = 1'b0;
        cpu.STB = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstfill_mem_stb", mem.STB, 1'b0);
        chk("rstfill_cpu_rty", cpu.RTY, 1'b0);
        chk("rstfill_cpu_dat_s", cpu.DAT_S, '0);

        mem_q.push_back('{1'b0, 12'h010, '0});
        exp_q.push_back(MRG);
        cpu_req(12'h010, 1'b0, '0, '0, rc, sc, ai);
        chk("postrst_miss_rty_cycles", rc, 3);

        mem_q.push_back('{1'b0, 12'h028, '0});
        @(posedge clk); #1;
        cpu.ADR = 12'h028;
        cpu.CYC = 1'b1;
        cpu.STB = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cpu.CYC = 1'b0;
        cpu.STB = 1'b0;
        repeat (8) @(posedge clk);
        exp_q.push_back(Z);
        cpu_req(12'h028, 1'b0, '0, '0, rc, sc, ai);
        chk("abort_fill_kept_rty", rc, 0);
        chk("abort_fill_kept_ack", ai, 1);

        repeat (3) @(posedge clk);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
